// File: rtl/idu_pkg.sv
// Shared decode definitions for the idu stage: opcodes, ALU op and immediate-format encodings,
// and the decoded control bundle.
package idu_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [1:0] MEM_BYTE = 2'd0;
  localparam logic [1:0] MEM_HALF = 2'd1;
  localparam logic [1:0] MEM_WORD = 2'd2;

  // 16 codes only: a branch carrying ALU_SLTU means BGEU (taken when NOT rs1 <u rs2).
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_COPY2 = 4'd10,
    ALU_BEQ   = 4'd11,
    ALU_BNE   = 4'd12,
    ALU_BLT   = 4'd13,
    ALU_BGE   = 4'd14,
    ALU_BLTU  = 4'd15
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_op_e    alu_op;
    logic       src1_pc;
    logic       src2_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       ecall;
    logic       ebreak;
    logic       illegal;
  } dec_t;

  // funct3 -> ALU op for OP/OP-IMM with funct7 == 0
  function automatic alu_op_e alu_base(input logic [2:0] f3);
    alu_op_e op;
    unique case (f3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/idu_imm_gen.sv
// Combinational RV32I immediate extractor; every format is sign-extended from inst[31].
module idu_imm_gen
  import idu_pkg::*;
(
  input  logic [31:0] i_inst,
  input  imm_type_e   i_imm_type,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = '0;
    case (i_imm_type)
      IMM_I:   o_imm = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S:   o_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:   o_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      IMM_U:   o_imm = {i_inst[31:12], 12'b0};
      IMM_J:   o_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      default: o_imm = '0;
    endcase
  end

endmodule

// File: rtl/idu.sv
// RV32I decode stage: combinational decode of the fetched word into a one-entry,
// full-throughput output register with valid/ready handshakes on both sides.
module idu
  import idu_pkg::*;
#(
  parameter int          RVE      = 0,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic [31:0] imm,
  output alu_op_e     alu_op,
  output logic        src1_pc,
  output logic        src2_imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic        mem_unsigned,
  output logic        branch,
  output logic        jal,
  output logic        jalr,
  output logic        ecall,
  output logic        ebreak,
  output logic        illegal
);

  logic [6:0]  w_opc_p0;
  logic [2:0]  w_f3_p0;
  logic [6:0]  w_f7_p0;
  logic [4:0]  w_rs1_f_p0;
  logic [4:0]  w_rs2_f_p0;
  logic [4:0]  w_rd_f_p0;
  dec_t        w_dec_p0;
  imm_type_e   w_imm_type_p0;
  logic [31:0] w_imm_p0;
  logic        w_bad_p0;
  logic        w_in_fire;

  logic        r_vld_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_inst_p1;
  dec_t        r_dec_p1;
  logic [31:0] r_imm_p1;

  assign w_opc_p0   = in_inst[6:0];
  assign w_f3_p0    = in_inst[14:12];
  assign w_f7_p0    = in_inst[31:25];
  assign w_rs1_f_p0 = in_inst[19:15];
  assign w_rs2_f_p0 = in_inst[24:20];
  assign w_rd_f_p0  = in_inst[11:7];

  always_comb begin
    w_dec_p0        = '0;
    w_dec_p0.alu_op = ALU_ADD;
    w_imm_type_p0   = IMM_NONE;
    w_bad_p0        = 1'b0;
    case (w_opc_p0)
      OPC_LUI: begin
        w_dec_p0.rd        = w_rd_f_p0;
        w_imm_type_p0      = IMM_U;
        w_dec_p0.alu_op    = ALU_COPY2;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_dec_p0.rd        = w_rd_f_p0;
        w_imm_type_p0      = IMM_U;
        w_dec_p0.src1_pc   = 1'b1;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_dec_p0.rd        = w_rd_f_p0;
        w_imm_type_p0      = IMM_J;
        w_dec_p0.jal       = 1'b1;
        w_dec_p0.src1_pc   = 1'b1;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.reg_write = 1'b1;
      end
      OPC_JALR: begin
        w_dec_p0.rs1       = w_rs1_f_p0;
        w_dec_p0.rd        = w_rd_f_p0;
        w_imm_type_p0      = IMM_I;
        w_dec_p0.jalr      = 1'b1;
        w_dec_p0.src1_pc   = 1'b1;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.reg_write = 1'b1;
        w_bad_p0           = (w_f3_p0 != 3'd0);
      end
      OPC_BRANCH: begin
        w_dec_p0.rs1    = w_rs1_f_p0;
        w_dec_p0.rs2    = w_rs2_f_p0;
        w_imm_type_p0   = IMM_B;
        w_dec_p0.branch = 1'b1;
        case (w_f3_p0)
          3'd0:    w_dec_p0.alu_op = ALU_BEQ;
          3'd1:    w_dec_p0.alu_op = ALU_BNE;
          3'd4:    w_dec_p0.alu_op = ALU_BLT;
          3'd5:    w_dec_p0.alu_op = ALU_BGE;
          3'd6:    w_dec_p0.alu_op = ALU_BLTU;
          3'd7:    w_dec_p0.alu_op = ALU_SLTU;
          default: w_bad_p0 = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        w_dec_p0.rs1          = w_rs1_f_p0;
        w_dec_p0.rd           = w_rd_f_p0;
        w_imm_type_p0         = IMM_I;
        w_dec_p0.mem_read     = 1'b1;
        w_dec_p0.reg_write    = 1'b1;
        w_dec_p0.src2_imm     = 1'b1;
        w_dec_p0.mem_size     = w_f3_p0[1:0];
        w_dec_p0.mem_unsigned = w_f3_p0[2];
        w_bad_p0              = (w_f3_p0 == 3'd3) || (w_f3_p0[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_dec_p0.rs1       = w_rs1_f_p0;
        w_dec_p0.rs2       = w_rs2_f_p0;
        w_imm_type_p0      = IMM_S;
        w_dec_p0.mem_write = 1'b1;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.mem_size  = w_f3_p0[1:0];
        w_bad_p0           = (w_f3_p0 >= 3'd3);
      end
      OPC_OPIMM: begin
        w_dec_p0.rs1       = w_rs1_f_p0;
        w_dec_p0.rd        = w_rd_f_p0;
        w_imm_type_p0      = IMM_I;
        w_dec_p0.src2_imm  = 1'b1;
        w_dec_p0.reg_write = 1'b1;
        w_dec_p0.alu_op    = alu_base(w_f3_p0);
        // Shift immediates reuse imm[11:5] as funct7; only SRAI may set it.
        if (w_f3_p0 == 3'd5 && w_f7_p0 == 7'h20) w_dec_p0.alu_op = ALU_SRA;
        else if (w_f3_p0 == 3'd1 || w_f3_p0 == 3'd5) w_bad_p0 = (w_f7_p0 != 7'h00);
      end
      OPC_OP: begin
        w_dec_p0.rs1       = w_rs1_f_p0;
        w_dec_p0.rs2       = w_rs2_f_p0;
        w_dec_p0.rd        = w_rd_f_p0;
        w_dec_p0.reg_write = 1'b1;
        if (w_f7_p0 == 7'h00) w_dec_p0.alu_op = alu_base(w_f3_p0);
        else if (w_f7_p0 == 7'h20 && w_f3_p0 == 3'd0) w_dec_p0.alu_op = ALU_SUB;
        else if (w_f7_p0 == 7'h20 && w_f3_p0 == 3'd5) w_dec_p0.alu_op = ALU_SRA;
        else w_bad_p0 = 1'b1;
      end
      OPC_FENCE: ;
      OPC_SYSTEM: begin
        w_dec_p0.ecall  = (in_inst == INST_ECALL);
        w_dec_p0.ebreak = (in_inst == INST_EBREAK);
        w_bad_p0        = !(w_dec_p0.ecall || w_dec_p0.ebreak);
      end
      default: w_bad_p0 = 1'b1;
    endcase
    if (RVE != 0 && (w_dec_p0.rs1[4] || w_dec_p0.rs2[4] || w_dec_p0.rd[4])) w_bad_p0 = 1'b1;
    if (w_dec_p0.rd == 5'd0) w_dec_p0.reg_write = 1'b0;
    if (w_bad_p0) begin
      w_dec_p0.reg_write = 1'b0;
      w_dec_p0.mem_read  = 1'b0;
      w_dec_p0.mem_write = 1'b0;
      w_dec_p0.branch    = 1'b0;
      w_dec_p0.jal       = 1'b0;
      w_dec_p0.jalr      = 1'b0;
      w_dec_p0.illegal   = 1'b1;
    end
  end

  idu_imm_gen u_imm_gen (
    .i_inst     (in_inst),
    .i_imm_type (w_imm_type_p0),
    .o_imm      (w_imm_p0)
  );

  assign in_ready  = !r_vld_p1 || out_ready;
  assign w_in_fire = in_valid && in_ready;

  // p0 -> p1: output register, refilled in the same cycle it drains
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_pc_p1   <= RESET_PC;
      r_inst_p1 <= '0;
      r_dec_p1  <= '0;
      r_imm_p1  <= '0;
    end else if (w_in_fire) begin
      r_vld_p1  <= 1'b1;
      r_pc_p1   <= in_pc;
      r_inst_p1 <= in_inst;
      r_dec_p1  <= w_dec_p0;
      r_imm_p1  <= w_imm_p0;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_valid    = r_vld_p1;
  assign out_pc       = r_pc_p1;
  assign out_inst     = r_inst_p1;
  assign imm          = r_imm_p1;
  assign rs1          = r_dec_p1.rs1;
  assign rs2          = r_dec_p1.rs2;
  assign rd           = r_dec_p1.rd;
  assign alu_op       = r_dec_p1.alu_op;
  assign src1_pc      = r_dec_p1.src1_pc;
  assign src2_imm     = r_dec_p1.src2_imm;
  assign reg_write    = r_dec_p1.reg_write;
  assign mem_read     = r_dec_p1.mem_read;
  assign mem_write    = r_dec_p1.mem_write;
  assign mem_size     = r_dec_p1.mem_size;
  assign mem_unsigned = r_dec_p1.mem_unsigned;
  assign branch       = r_dec_p1.branch;
  assign jal          = r_dec_p1.jal;
  assign jalr         = r_dec_p1.jalr;
  assign ecall        = r_dec_p1.ecall;
  assign ebreak       = r_dec_p1.ebreak;
  assign illegal      = r_dec_p1.illegal;

endmodule

// File: tb/tb_idu.sv
// Bench for idu: directed vector table, handshake/reset sequences, and randomized traffic
// scored against a format-level decode model, for both RV32I and RV32E builds.
module tb_idu;
  import idu_pkg::*;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        src1_pc, src2_imm, reg_write, mem_read, mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned, branch, jal, jalr, ecall, ebreak, illegal;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        ill, rw, mw, ebrk, eill;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } tx_t;

  localparam logic [3:0] BASE_ALU [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                                          ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [3:0] BR_ALU [8]   = '{ALU_BEQ, ALU_BNE, ALU_ADD, ALU_ADD,
                                          ALU_BLT, ALU_BGE, ALU_BLTU, ALU_SLTU};
  localparam logic [6:0] OPCS [11]    = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                          7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid, out_ready;
  logic [31:0] in_inst, in_pc;

  logic in_ready, out_valid, src1_pc, src2_imm, reg_write, mem_read, mem_write;
  logic mem_unsigned, branch, jal, jalr, ecall, ebreak, illegal;
  logic [31:0] out_pc, out_inst, imm;
  logic [4:0] rs1, rs2, rd;
  logic [3:0] alu_op;
  logic [1:0] mem_size;

  logic e_in_ready, e_out_valid, e_src1_pc, e_src2_imm, e_reg_write, e_mem_read, e_mem_write;
  logic e_mem_unsigned, e_branch, e_jal, e_jalr, e_ecall, e_ebreak, e_illegal;
  logic [31:0] e_out_pc, e_out_inst, e_imm;
  logic [4:0] e_rs1, e_rs2, e_rd;
  logic [3:0] e_alu_op;
  logic [1:0] e_mem_size;

  exp_t act, eact;
  int checks = 0;
  int errors = 0;
  vec_t tbl [10];
  tx_t q [$];
  logic [129:0] prev_snap;
  bit prev_stall = 1'b0;

  always #5 clk = ~clk;

  idu #(.RVE(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_op(alu_op),
    .src1_pc(src1_pc), .src2_imm(src2_imm), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .branch(branch), .jal(jal), .jalr(jalr), .ecall(ecall), .ebreak(ebreak), .illegal(illegal)
  );

  idu #(.RVE(1)) u_dut_e (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_out_pc),
    .out_inst(e_out_inst), .rs1(e_rs1), .rs2(e_rs2), .rd(e_rd), .imm(e_imm), .alu_op(e_alu_op),
    .src1_pc(e_src1_pc), .src2_imm(e_src2_imm), .reg_write(e_reg_write), .mem_read(e_mem_read),
    .mem_write(e_mem_write), .mem_size(e_mem_size), .mem_unsigned(e_mem_unsigned),
    .branch(e_branch), .jal(e_jal), .jalr(e_jalr), .ecall(e_ecall), .ebreak(e_ebreak),
    .illegal(e_illegal)
  );

  assign act  = {rs1, rs2, rd, imm, alu_op, src1_pc, src2_imm, reg_write, mem_read, mem_write,
                 mem_size, mem_unsigned, branch, jal, jalr, ecall, ebreak, illegal};
  assign eact = {e_rs1, e_rs2, e_rd, e_imm, e_alu_op, e_src1_pc, e_src2_imm, e_reg_write,
                 e_mem_read, e_mem_write, e_mem_size, e_mem_unsigned, e_branch, e_jal, e_jalr,
                 e_ecall, e_ebreak, e_illegal};

  task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, a, e);
    end
  endtask

  // Reference decode written from the instruction-format rules.
  function automatic exp_t model(input logic [31:0] i, input bit rve);
    exp_t e;
    bit bad, u1, u2, ud;
    byte fmt;
    logic signed [31:0] si;
    logic [31:0] a20, a31;
    logic [2:0] f3;
    logic [6:0] f7;
    e = '0; e.alu = ALU_ADD; bad = 0; u1 = 0; u2 = 0; ud = 0; fmt = "N";
    f3 = i[14:12]; f7 = i[31:25];
    si = i; a20 = si >>> 20; a31 = si >>> 31;
    case (i[6:0])
      7'h37: begin ud = 1; fmt = "U"; e.alu = ALU_COPY2; e.src2_imm = 1; e.reg_write = 1; end
      7'h17: begin ud = 1; fmt = "U"; e.src1_pc = 1; e.src2_imm = 1; e.reg_write = 1; end
      7'h6F: begin ud = 1; fmt = "J"; e.jal = 1; e.src1_pc = 1; e.src2_imm = 1; e.reg_write = 1; end
      7'h67: begin
        u1 = 1; ud = 1; fmt = "I"; e.jalr = 1; e.src1_pc = 1; e.src2_imm = 1; e.reg_write = 1;
        bad = (f3 != 0);
      end
      7'h63: begin
        u1 = 1; u2 = 1; fmt = "B"; e.branch = 1; e.alu = BR_ALU[f3]; bad = (f3 == 2 || f3 == 3);
      end
      7'h03: begin
        u1 = 1; ud = 1; fmt = "I"; e.mem_read = 1; e.reg_write = 1; e.src2_imm = 1;
        e.mem_size = f3[1:0]; e.mem_unsigned = f3[2]; bad = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        u1 = 1; u2 = 1; fmt = "S"; e.mem_write = 1; e.src2_imm = 1; e.mem_size = f3[1:0];
        bad = (f3 >= 3);
      end
      7'h13: begin
        u1 = 1; ud = 1; fmt = "I"; e.src2_imm = 1; e.reg_write = 1; e.alu = BASE_ALU[f3];
        if (f3 == 1) bad = (f7 != 0);
        if (f3 == 5) begin
          if (f7 == 7'h20) e.alu = ALU_SRA;
          else bad = (f7 != 0);
        end
      end
      7'h33: begin
        u1 = 1; u2 = 1; ud = 1; e.reg_write = 1;
        if (f7 == 0) e.alu = BASE_ALU[f3];
        else if (f7 == 7'h20 && f3 == 0) e.alu = ALU_SUB;
        else if (f7 == 7'h20 && f3 == 5) e.alu = ALU_SRA;
        else bad = 1;
      end
      7'h0F: ;
      7'h73: begin
        e.ecall = (i == 32'h0000_0073); e.ebreak = (i == 32'h0010_0073);
        bad = !(e.ecall || e.ebreak);
      end
      default: bad = 1;
    endcase
    case (fmt)
      "I": e.imm = a20;
      "S": e.imm = (a20 & ~32'h1F) | ((i >> 7) & 32'h1F);
      "B": e.imm = (a31 & 32'hFFFF_F000) | ((i >> 20) & 32'h7E0) | ((i << 4) & 32'h800)
                   | ((i >> 7) & 32'h1E);
      "U": e.imm = i & 32'hFFFF_F000;
      "J": e.imm = (a31 & 32'hFFF0_0000) | (i & 32'h000F_F000) | ((i >> 9) & 32'h800)
                   | ((i >> 20) & 32'h7FE);
      default: e.imm = 0;
    endcase
    e.rs1 = u1 ? i[19:15] : 5'd0;
    e.rs2 = u2 ? i[24:20] : 5'd0;
    e.rd  = ud ? i[11:7]  : 5'd0;
    if (rve && (e.rs1 >= 16 || e.rs2 >= 16 || e.rd >= 16)) bad = 1;
    if (e.rd == 0) e.reg_write = 0;
    if (bad) begin
      e.reg_write = 0; e.mem_read = 0; e.mem_write = 0;
      e.branch = 0; e.jal = 0; e.jalr = 0; e.illegal = 1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int s;
    r = $urandom;
    s = $urandom_range(0, 15);
    if (s < 11) return {r[31:7], OPCS[s]};
    if (s == 11) return 32'h0000_0073;
    if (s == 12) return 32'h0010_0073;
    if (s == 13) return {1'b0, r[30], 5'b0, r[24:7], 7'h13};
    if (s == 14) return {1'b0, r[30], 5'b0, r[24:7], 7'h33};
    return r;
  endfunction

  // One negedge of scoreboard work: drain before refill, then stall stability.
  task automatic sb_step();
    tx_t h;
    logic [129:0] snap;
    chk("in_ready", 160'(in_ready), 160'(!out_valid || out_ready));
    chk("e_in_ready", 160'(e_in_ready), 160'(!e_out_valid || out_ready));
    chk("valid_vs_sb", 160'(out_valid), 160'(q.size() != 0));
    if (out_valid && out_ready && q.size() != 0) begin
      h = q.pop_front();
      chk("rand_bundle", 160'(act), 160'(model(h.inst, 1'b0)));
      chk("rand_bundle_rve", 160'(eact), 160'(model(h.inst, 1'b1)));
      chk("rand_pc", 160'({out_pc, e_out_pc}), 160'({h.pc, h.pc}));
      chk("rand_inst", 160'(out_inst), 160'(h.inst));
    end
    if (in_valid && in_ready) q.push_back('{inst: in_inst, pc: in_pc});
    snap = {act, out_pc, out_inst, out_valid};
    if (prev_stall) chk("stall_hold", 160'(snap), 160'(prev_snap));
    prev_stall = out_valid && !out_ready;
    prev_snap  = snap;
  endtask

  initial begin
    exp_t saved;
    tbl[0] = '{32'h00500093, 5'd1 - 5'd1, 5'd0, 5'd1,  32'h5,         ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'hFE20AE23, 5'd1, 5'd2, 5'd0,  32'hFFFF_FFFC,  ALU_ADD,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{32'h123452B7, 5'd0, 5'd0, 5'd5,  32'h1234_5000,  ALU_COPY2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{32'h00100073, 5'd0, 5'd0, 5'd0,  32'h0,          ALU_ADD,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{32'h00000000, 5'd0, 5'd0, 5'd0,  32'h0,          ALU_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{32'h002081B3, 5'd1, 5'd2, 5'd3,  32'h0,          ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h402081B3, 5'd1, 5'd2, 5'd3,  32'h0,          ALU_SUB,   1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{32'h40109093, 5'd1, 5'd0, 5'd1,  32'h401,        ALU_SLL,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{32'h0000B003, 5'd1, 5'd0, 5'd0,  32'h0,          ALU_ADD,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[9] = '{32'h00208833, 5'd1, 5'd2, 5'd16, 32'h0,          ALU_ADD,   1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 1; rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 160'(out_valid), 160'(0));
    chk("rst_pc", 160'(out_pc), 160'(32'h8000_0000));
    chk("rst_fields", 160'({act, out_inst}), 160'(0));
    chk("rst_in_ready", 160'(in_ready), 160'(1));
    rst = 0;

    // Back-to-back table traffic with out_ready held high: no bubbles expected.
    in_valid = 1; in_inst = tbl[0].inst; in_pc = 32'h1000;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("tbl_valid", 160'({out_valid, in_ready}), 160'(2'b11));
      chk("tbl_fields", 160'({rs1, rs2, rd, imm, alu_op, illegal, reg_write, mem_write, ebreak}),
          160'({tbl[k].rs1, tbl[k].rs2, tbl[k].rd, tbl[k].imm, tbl[k].alu, tbl[k].ill,
                tbl[k].rw, tbl[k].mw, tbl[k].ebrk}));
      chk("tbl_pc_inst", 160'({out_pc, out_inst}), 160'({32'h1000 + 32'(4 * k), tbl[k].inst}));
      chk("tbl_bundle", 160'(act), 160'(model(tbl[k].inst, 1'b0)));
      chk("tbl_rve_illegal", 160'(e_illegal), 160'(tbl[k].eill));
      if (k < 9) begin
        in_inst = tbl[k + 1].inst; in_pc = 32'h1000 + 32'(4 * (k + 1));
      end else begin
        in_valid = 0;
      end
    end
    chk("sw_size", 160'({mem_size, mem_read}), 160'(0));

    // Backpressure: hold addi for 3 cycles while sw waits, then same-cycle refill.
    @(posedge clk); #1;
    in_valid = 1; in_inst = 32'h00500093; in_pc = 32'h2000;
    @(posedge clk); #1;
    out_ready = 0; in_inst = 32'hFE20AE23; in_pc = 32'h2004;
    saved = act;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("bp_in_ready", 160'(in_ready), 160'(0));
      chk("bp_hold", 160'({act, out_pc, out_inst, out_valid}),
          160'({saved, 32'h2000, 32'h00500093, 1'b1}));
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_ready", 160'(in_ready), 160'(1));
    @(posedge clk); #1;
    chk("bp_refill", 160'({act, out_pc, out_valid}), 160'({model(32'hFE20AE23, 1'b0), 32'h2004, 1'b1}));
    in_valid = 0; in_inst = 32'hDEAD_BEEF;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("idle_stable", 160'({act, out_pc, out_inst, out_valid}),
          160'({model(32'hFE20AE23, 1'b0), 32'h2004, 32'hFE20AE23, 1'b0}));
    end

    // Reset while a bundle is stalled drops it.
    in_valid = 1; in_inst = 32'h123452B7; in_pc = 32'h3000; out_ready = 0;
    @(posedge clk); #1;
    chk("stall_valid", 160'(out_valid), 160'(1));
    in_valid = 0; rst = 1;
    @(posedge clk); #1;
    rst = 0;
    chk("rst_stall_valid", 160'({out_valid, in_ready}), 160'(2'b01));
    chk("rst_stall_state", 160'({act, out_pc, out_inst}), 160'({65'b0, 32'h8000_0000, 32'h0}));

    // Randomized traffic against the scoreboard.
    out_ready = 1;
    @(posedge clk);
    for (int n = 0; n < 800; n++) begin
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_inst   = rand_inst();
      in_pc     = $urandom & 32'hFFFF_FFFC;
      @(negedge clk);
      sb_step();
      @(posedge clk);
    end
    #1;
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    sb_step();
    chk("sb_empty", 160'(q.size()), 160'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu.md
Name: idu

Overview:
- Decode stage directly downstream of the instruction-fetch stage in the npc core.
- Accepts a fetched 32-bit RV32I instruction and its PC over a valid/ready handshake.
- Decodes register indices, the immediate and control signals, and holds them in a one-entry output register for the execute stage.
- No register-file access and no hazard logic; those belong to neighbouring blocks.

Parameters:
- RVE, 0, when 1 any used register index >= 16 raises illegal (RV32E mode).
- RESET_PC, 32'h8000_0000, reset value of out_pc.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  fetch stage presents instruction
- in_ready  output  1  idu can accept this cycle
- in_inst  input  32  instruction word
- in_pc  input  32  PC of in_inst
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  execute stage accepts bundle
- out_pc  output  32  registered PC
- out_inst  output  32  registered raw instruction
- rs1, rs2, rd  output  5 each  register indices (0 when unused)
- imm  output  32  sign/zero-extended immediate
- alu_op  output  4  idu_pkg::alu_op_e
- src1_pc  output  1  ALU operand1 = pc (auipc/jal/jalr link)
- src2_imm  output  1  ALU operand2 = imm
- reg_write  output  1  writes rd (forced 0 when rd==0)
- mem_read, mem_write  output  1 each  load/store
- mem_size  output  2  0=byte, 1=half, 2=word
- mem_unsigned  output  1  lbu/lhu
- branch  output  1  conditional branch; funct3 carried in alu_op compare encoding
- jal, jalr, ecall, ebreak  output  1 each
- illegal  output  1  undecodable encoding

Behaviour:
- Handshake: in_ready = !out_valid || out_ready (combinational). Transfer on in_valid && in_ready; out transfer on out_valid && out_ready.
- Latency 1: decode is combinational on in_inst; all decoded fields, out_pc and out_inst register on input transfer. out_valid is set the following cycle.
- out_valid next: 1 if input transfer; else 0 if output transfer; else hold. A simultaneous output and input transfer refills the register with no bubble (full throughput).
- Stall: out_valid=1, out_ready=0 -> in_ready=0 and every output stable, bit for bit.
- in_valid=0 and no output transfer -> register unchanged. Fields are don't-care when out_valid=0 but must not toggle without an input transfer.
- Reset: out_valid=0, out_pc=RESET_PC, out_inst=0, every other output 0. Reset mid-stall drops the held bundle with no output transfer; in_ready=1 the first cycle after reset.
- Immediates:
  - I: inst[31:20] sign-extended.
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - All sign-extended to 32 bits. R-type imm=0.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM (ecall 0x00000073, ebreak 0x00100073 only). FENCE decodes as a nop: alu ADD, no writes.
- Illegal cases:
  - unknown opcode; inst[1:0] != 2'b11
  - bad funct3/funct7 combination (e.g. SLLI funct7 != 0, OP funct7 not in {0, 0x20}, SUB/SRA only where legal)
  - LOAD funct3 in {3,6,7}; STORE funct3 >= 3
  - RVE=1 and any used index >= 16
- On illegal: reg_write, mem_read, mem_write, branch, jal, jalr = 0; illegal=1; bundle still passes through the handshake.
- lui: alu_op COPY2 (result = imm), rs1 = 0.
- Unused register fields driven 0, never raw instruction bits.

Decomposition:
- idu_pkg:
  - opcode localparams (OPC_LUI=7'b0110111, …)
  - alu_op_e enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY2, BEQ, BNE, BLT, BGE, BLTU, BGEU (4-bit max 16: fold BGEU into SLTU+invert if required; implementer fixes the encoding in the package)
  - imm_type_e: I, S, B, U, J, NONE
  - mem_size constants
- Sub-module idu_imm_gen: combinational, inputs inst and imm_type_e, output 32-bit imm.

Test Plan:
- addi x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu ADD, src2_imm=1, reg_write=1, illegal=0.
- sw x2,-4(x1) (0xFE20AE23) -> rs1=1, rs2=2, imm=0xFFFFFFFC, mem_write=1, mem_size=2, reg_write=0.
- lui x5,0x12345 (0x123452B7) then ebreak (0x00100073) back-to-back, out_ready=1 -> imm=0x12345000, rd=5; next cycle ebreak=1; no bubble, in_ready stays 1.
- Backpressure: bundle held, out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs unchanged. out_ready=1 -> same-cycle refill with the pending instruction.
- 0x00000000 -> illegal=1, all write/mem/branch flags 0. With RVE=1, add x16,x1,x2 (0x00208833) -> illegal=1.
- Assert rst while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_pc=0x80000000, in_ready=1.
